wb_arbiter: RTL and testbench

Writeback arbiter that merges results from the ALU and the load/store unit into the single write port of the 32×32 register file. Each source has a 2-entry FIFO with a valid/ready handshake. A round-robin arbiter drains at most one entry per cycle into a registered write port. A pending-write mask is exported so upstream hazard logic can stall on registers with queued writes.

---
 rtl/wb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU and LSU results queue in per-source FIFOs and share one register-file write port.
// Latency 2 cycles accept-to-write_rg (1 cycle when WB_BYPASS_EN is defined and the source wins on arrival).
// Backpressure: alu_ready/lsu_ready drop while the source FIFO is full; at most one write is drained per cycle.

module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_dat,
    input  logic                      pop,
    output logic [W-1:0]              head_dat,
    output logic                      empty,
    output logic                      full,
    output logic [DEPTH-1:0][W-1:0]   entries,
    output logic [DEPTH-1:0]          entry_vld
);
    // Circular FIFO; exposes every slot plus a valid bit so the owner can scan queued contents.
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic [AW:0]             cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= push_dat;
    end

    assign head_dat = mem[rptr];
    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign entries  = mem;

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++)
            entry_vld[i] = ({1'b0, AW'(AW'(i) - rptr)} < cnt);
    end
endmodule

module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic [4:0]  write_rg,
    output logic [31:0] write_data,
    output logic [31:0] pend_mask
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic {GNT_ALU, GNT_LSU} grant_t;

    localparam int W = $bits(wb_entry_t);

    grant_t                  last_grant;
    wb_entry_t               alu_in, lsu_in, alu_head, lsu_head, grant_ent;
    wb_entry_t [DEPTH-1:0]   alu_ents, lsu_ents;
    logic [DEPTH-1:0]        alu_vld, lsu_vld;
    logic                    alu_empty, alu_full, lsu_empty, lsu_full;
    logic                    alu_fire, lsu_fire, alu_req, lsu_req;
    logic                    grant_alu, grant_lsu, alu_byp, lsu_byp;
    logic                    alu_push, lsu_push, alu_pop, lsu_pop;

    assign alu_in    = '{rd: alu_rd, data: alu_data};
    assign lsu_in    = '{rd: lsu_rd, data: lsu_data};
    assign alu_ready = !alu_full;
    assign lsu_ready = !lsu_full;

    // rd==0 transfers complete the handshake but carry no write.
    assign alu_fire = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign lsu_fire = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

`ifdef WB_BYPASS_EN
    assign alu_req = !alu_empty || alu_fire;
    assign lsu_req = !lsu_empty || lsu_fire;
`else
    assign alu_req = !alu_empty;
    assign lsu_req = !lsu_empty;
`endif

    assign grant_alu = alu_req && (!lsu_req || (last_grant == GNT_LSU));
    assign grant_lsu = lsu_req && !grant_alu;

    // A grant against an empty FIFO can only come from the bypass path.
    assign alu_byp  = grant_alu && alu_empty;
    assign lsu_byp  = grant_lsu && lsu_empty;
    assign alu_push = alu_fire && !alu_byp;
    assign lsu_push = lsu_fire && !lsu_byp;
    assign alu_pop  = grant_alu && !alu_empty;
    assign lsu_pop  = grant_lsu && !lsu_empty;

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_push),
        .push_dat  (alu_in),
        .pop       (alu_pop),
        .head_dat  (alu_head),
        .empty     (alu_empty),
        .full      (alu_full),
        .entries   (alu_ents),
        .entry_vld (alu_vld)
    );

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_lsu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lsu_push),
        .push_dat  (lsu_in),
        .pop       (lsu_pop),
        .head_dat  (lsu_head),
        .empty     (lsu_empty),
        .full      (lsu_full),
        .entries   (lsu_ents),
        .entry_vld (lsu_vld)
    );

    always_comb begin
        grant_ent = '0;
        if (grant_alu)
            grant_ent = alu_empty ? alu_in : alu_head;
        else if (grant_lsu)
            grant_ent = lsu_empty ? lsu_in : lsu_head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_rg   <= '0;
            write_data <= '0;
            last_grant <= GNT_LSU;
        end else begin
            write_rg   <= grant_ent.rd;
            write_data <= grant_ent.data;
            if (grant_alu)
                last_grant <= GNT_ALU;
            else if (grant_lsu)
                last_grant <= GNT_LSU;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_vld[i])
                pend_mask[alu_ents[i].rd] = 1'b1;
            if (lsu_vld[i])
                pend_mask[lsu_ents[i].rd] = 1'b1;
        end
        pend_mask[write_rg] = 1'b1;
        pend_mask[0]        = 1'b0;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (default build, DEPTH=2): latency, alternation, backpressure, rd=0, async reset.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic [4:0]  write_rg;
    logic [31:0] write_data, pend_mask;

    int total  = 0;
    int passed = 0;

    wb_arbiter #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .write_rg   (write_rg),
        .write_data (write_data),
        .pend_mask  (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  a_rd [4];
        logic [31:0] a_dat[4];
        logic [4:0]  l_rd [4];
        logic [31:0] l_dat[4];
        int ai, li, k;
        logic acc_a, acc_l;

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_rg", write_rg, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_lsu_ready", lsu_ready, 1);
        rst = 1'b0;

        // Single ALU write: accepted at N, visible after N+1 for one cycle
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        chk("single_n_rg", write_rg, 0);
        chk("single_n_pend", pend_mask, 32'h0000_0020);
        tick();
        chk("single_n1_rg", write_rg, 5);
        chk("single_n1_data", write_data, 32'hDEADBEEF);
        chk("single_n1_pend", pend_mask, 32'h0000_0020);
        tick();
        chk("single_n2_rg", write_rg, 0);
        chk("single_n2_data", write_data, 0);
        chk("single_n2_pend", pend_mask, 0);

        // Single LSU write leaves last_grant = LSU
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hCAFEF00D;
        tick();
        lsu_valid = 1'b0;
        tick();
        chk("lsu_single_rg", write_rg, 7);
        chk("lsu_single_data", write_data, 32'hCAFEF00D);
        tick();
        chk("lsu_single_end", write_rg, 0);

        // rd=0 transfer is consumed and discarded
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
        #1;
        chk("rd0_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("rd0_rg_a", write_rg, 0);
        chk("rd0_pend_a", pend_mask, 0);
        tick();
        chk("rd0_rg_b", write_rg, 0);
        chk("rd0_data_b", write_data, 0);
        chk("rd0_pend_b", pend_mask, 0);

        // Both sources saturated: ALU, LSU, ALU, ... one write per cycle
        for (int i = 0; i < 4; i++) begin
            a_rd[i]  = 5'(1 + i);   a_dat[i] = 32'hA000_0000 + 32'(i);
            l_rd[i]  = 5'(11 + i);  l_dat[i] = 32'hB000_0000 + 32'(i);
        end
        ai = 0; li = 0;
        alu_valid = 1'b1; alu_rd = a_rd[0]; alu_data = a_dat[0];
        lsu_valid = 1'b1; lsu_rd = l_rd[0]; lsu_data = l_dat[0];
        for (int c = 0; c < 10; c++) begin
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            tick();
            if (acc_a) ai++;
            if (acc_l) li++;
            alu_valid = (ai < 4);
            if (ai < 4) begin alu_rd = a_rd[ai]; alu_data = a_dat[ai]; end
            lsu_valid = (li < 4);
            if (li < 4) begin lsu_rd = l_rd[li]; lsu_data = l_dat[li]; end
            if (c >= 1 && c <= 8) begin
                k = c - 1;
                chk($sformatf("sat_rg_%0d", k), write_rg, (k % 2 == 0) ? a_rd[k/2] : l_rd[k/2]);
                chk($sformatf("sat_data_%0d", k), write_data, (k % 2 == 0) ? a_dat[k/2] : l_dat[k/2]);
            end
        end
        chk("sat_idle_rg", write_rg, 0);
        chk("sat_idle_pend", pend_mask, 0);
        chk("sat_alu_accepted", ai, 4);
        chk("sat_lsu_accepted", li, 4);

        // LSU held valid for three items while ALU wins the first tie
        alu_valid = 1'b1; alu_rd = 5'd19; alu_data = 32'h0000_0019;
        lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'h0000_0021;
        tick();
        chk("hold_e1_rg", write_rg, 0);
        chk("hold_e1_pend", pend_mask, 32'h0028_0000);
        alu_rd = 5'd20; alu_data = 32'h0000_0020;
        lsu_rd = 5'd22; lsu_data = 32'h0000_0022;
        tick();
        alu_valid = 1'b0;
        lsu_rd = 5'd23; lsu_data = 32'h0000_0023;
        chk("hold_e2_rg", write_rg, 19);
        chk("hold_e2_pend", pend_mask, 32'h0078_0000);
        chk("hold_e2_lsu_ready", lsu_ready, 0);
        chk("hold_e2_alu_ready", alu_ready, 1);
        tick();
        chk("hold_e3_rg", write_rg, 21);
        chk("hold_e3_data", write_data, 32'h0000_0021);
        chk("hold_e3_lsu_ready", lsu_ready, 1);
        chk("hold_e3_pend", pend_mask, 32'h0070_0000);
        tick();
        lsu_valid = 1'b0;
        chk("hold_e4_rg", write_rg, 20);
        chk("hold_e4_pend", pend_mask, 32'h00D0_0000);
        tick();
        chk("hold_e5_rg", write_rg, 22);
        tick();
        chk("hold_e6_rg", write_rg, 23);
        chk("hold_e6_data", write_data, 32'h0000_0023);
        tick();
        chk("hold_e7_rg", write_rg, 0);
        chk("hold_e7_pend", pend_mask, 0);

        // Asynchronous reset with writes queued and one on the port
        alu_valid = 1'b1; alu_rd = 5'd24; alu_data = 32'h0000_0024;
        lsu_valid = 1'b1; lsu_rd = 5'd25; lsu_data = 32'h0000_0025;
        tick();
        alu_rd = 5'd26; alu_data = 32'h0000_0026;
        lsu_rd = 5'd27; lsu_data = 32'h0000_0027;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("arst_pre_rg", write_rg, 24);
        chk("arst_pre_pend", pend_mask, 32'h0F00_0000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rg", write_rg, 0);
        chk("arst_data", write_data, 0);
        chk("arst_pend", pend_mask, 0);
        chk("arst_alu_ready", alu_ready, 1);
        chk("arst_lsu_ready", lsu_ready, 1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst_rg_%0d", c), write_rg, 0);
            chk($sformatf("post_rst_pend_%0d", c), pend_mask, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
